// File: rtl/slt_arbiter_if.sv
// rtl/slt_arbiter_if.sv - client request/response bundle for slt_arbiter
// req_unsigned exists only when SLT_ARB_UNSIGNED_EN is defined.
interface slt_arbiter_if #(
  parameter int N          = 32,
  parameter int REQUESTERS = 4
);
  logic [REQUESTERS-1:0]   req_valid;
  logic [REQUESTERS-1:0]   req_ready;
  logic [REQUESTERS*N-1:0] req_a;
  logic [REQUESTERS*N-1:0] req_b;
`ifdef SLT_ARB_UNSIGNED_EN
  logic [REQUESTERS-1:0]   req_unsigned;
`endif
  logic [REQUESTERS-1:0]   resp_valid;
  logic                    resp_lt;
  logic                    busy;

`ifdef SLT_ARB_UNSIGNED_EN
  modport master (output req_valid, req_a, req_b, req_unsigned,
                  input  req_ready, resp_valid, resp_lt, busy);
  modport slave  (input  req_valid, req_a, req_b, req_unsigned,
                  output req_ready, resp_valid, resp_lt, busy);
`else
  modport master (output req_valid, req_a, req_b,
                  input  req_ready, resp_valid, resp_lt, busy);
  modport slave  (input  req_valid, req_a, req_b,
                  output req_ready, resp_valid, resp_lt, busy);
`endif
endinterface

// File: rtl/slt_arbiter.sv
// rtl/slt_arbiter.sv - round-robin shared signed less-than comparator for several clients
// SLT_ARB_UNSIGNED_EN adds a per-client unsigned compare select.
module ripple_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);
  logic [N:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
endmodule

module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  logic [N-1:0] diff;

  ripple_adder #(.N(N)) u_sub (.a(a), .b(~b), .cin(1'b1), .sum(diff));

  // Differing signs decide directly; this avoids subtraction overflow at the extremes.
  assign lt = (a[N-1] ^ b[N-1]) ? a[N-1] : diff[N-1];
endmodule

module slt_arbiter #(
  parameter int N          = 32,
  parameter int REQUESTERS = 4
) (
  input logic          clk,
  input logic          rst,
  slt_arbiter_if.slave bus
);
  localparam int PW = $clog2(REQUESTERS);
  localparam logic [REQUESTERS-1:0] ONE = {{(REQUESTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, gnt, sel;
  logic                  found;
  int                    idx;
  logic [REQUESTERS-1:0] ready;
  logic [REQUESTERS-1:0] resp_vld;
  logic                  accept;
  logic [N-1:0]          op_a, op_b, cmp_a, cmp_b;
  logic                  cmp_lt, lt_q, busy_q;

  // First valid client at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    resp_vld  = '0;
    unique case (state)
      IDLE: begin
        if (found && !rst) begin
          ready     = ONE << sel;
          state_nxt = COMPARE;
        end
      end
      COMPARE: state_nxt = RESPOND;
      RESPOND: begin
        resp_vld  = ONE << gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      gnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      lt_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      if (accept) begin
        op_a   <= bus.req_a[sel*N +: N];
        op_b   <= bus.req_b[sel*N +: N];
        gnt    <= sel;
        rr_ptr <= (sel == PW'(REQUESTERS - 1)) ? '0 : sel + 1'b1;
      end
      if (state == COMPARE) lt_q <= cmp_lt;
    end
  end

`ifdef SLT_ARB_UNSIGNED_EN
  logic op_uns;

  always_ff @(posedge clk) begin
    if (rst)         op_uns <= 1'b0;
    else if (accept) op_uns <= bus.req_unsigned[sel];
  end

  // Flipping both MSBs maps unsigned order onto signed order.
  assign cmp_a = {op_a[N-1] ^ op_uns, op_a[N-2:0]};
  assign cmp_b = {op_b[N-1] ^ op_uns, op_b[N-2:0]};
`else
  assign cmp_a = op_a;
  assign cmp_b = op_b;
`endif

  comparator_lt #(.N(N)) u_cmp (.a(cmp_a), .b(cmp_b), .lt(cmp_lt));

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_vld;
  assign bus.resp_lt    = lt_q;
  assign bus.busy       = busy_q;
endmodule
